// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants and the occupancy/state encoding for the front-end pipeline stage.
package pipe_pkg;

  localparam int PC_W_DEF   = 64;
  localparam int INST_W_DEF = 32;

  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

  // State encoding doubles as the occupancy count reported to the outside.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between an upstream producer, the stage and its downstream consumer.
interface pipe_skid_stage_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              flush;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, occupancy
  );
endinterface

// File: rtl/pipe_skid_stage_entry.sv
// One valid+payload holding register; clear wins over load, payload kept on clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with optional one-entry skid buffer, flush and occupancy report.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                PC_W        = PC_W_DEF,
  parameter int                INST_W      = INST_W_DEF,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(RISCV_NOP),
  parameter bit                SKID_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_skid_stage_if.slave      bus
);

  occ_e              r_state;
  occ_e              w_state_nxt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_consume;
  logic              w_main_load;
  logic              w_main_clr;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic              w_main_valid;
  logic [PC_W-1:0]   w_main_pc;
  logic [INST_W-1:0] w_main_inst;
  logic              w_skid_valid;
  logic [PC_W-1:0]   w_skid_pc;
  logic [INST_W-1:0] w_skid_inst;
  logic [PC_W-1:0]   w_main_d_pc;
  logic [INST_W-1:0] w_main_d_inst;

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_consume = w_main_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= OCC_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_clr       = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (bus.flush) begin
      w_state_nxt = OCC_EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      unique case (r_state)
        OCC_EMPTY: if (w_accept) begin
          w_state_nxt = OCC_ONE;
          w_main_load = 1'b1;
        end
        OCC_ONE: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = OCC_FULL;
            w_skid_load = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = OCC_EMPTY;
            w_main_clr  = 1'b1;
          end
        end
        OCC_FULL: if (w_consume && w_skid_valid) begin
          w_state_nxt      = OCC_ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clr       = 1'b1;
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  assign w_main_d_pc   = w_main_from_skid ? w_skid_pc   : bus.in_pc;
  assign w_main_d_inst = w_main_from_skid ? w_skid_inst : bus.in_inst;

  pipe_entry #(.PC_W(PC_W), .INST_W(INST_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clr),
    .i_pc    (w_main_d_pc),
    .i_inst  (w_main_d_inst),
    .o_valid (w_main_valid),
    .o_pc    (w_main_pc),
    .o_inst  (w_main_inst)
  );

  // With the skid entry, in_ready is a flop so it never depends on out_ready.
  if (SKID_EN) begin : g_skid
    logic r_in_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_in_ready <= 1'b1;
      else       r_in_ready <= (w_state_nxt != OCC_FULL);
    end

    assign w_in_ready = r_in_ready;

    pipe_entry #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clr),
      .i_pc    (bus.in_pc),
      .i_inst  (bus.in_inst),
      .o_valid (w_skid_valid),
      .o_pc    (w_skid_pc),
      .o_inst  (w_skid_inst)
    );
  end else begin : g_noskid
    assign w_in_ready   = bus.out_ready | ~w_main_valid;
    assign w_skid_valid = 1'b0;
    assign w_skid_pc    = '0;
    assign w_skid_inst  = '0;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_pc    = w_main_pc;
  assign bus.out_inst  = w_main_valid ? w_main_inst : BUBBLE_INST;
  assign bus.occupancy = r_state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: skid build (a) and combinational-ready build (b).
module tb_pipe_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;
  localparam logic [31:0] I2  = 32'h0020_81B3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipe_skid_stage_if #(.PC_W(64), .INST_W(32)) a_if ();
  pipe_skid_stage_if #(.PC_W(64), .INST_W(32)) b_if ();

  pipe_skid_stage #(.PC_W(64), .INST_W(32), .BUBBLE_INST(NOP), .SKID_EN(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  pipe_skid_stage #(.PC_W(64), .INST_W(32), .BUBBLE_INST(NOP), .SKID_EN(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [63:0] pc,
                       input logic [31:0] inst, input logic [1:0] occ, input logic rdy);
    check({tag, ".a.out_valid"}, 64'(a_if.out_valid), 64'(v));
    if (v) check({tag, ".a.out_pc"}, a_if.out_pc, pc);
    check({tag, ".a.out_inst"}, 64'(a_if.out_inst), 64'(inst));
    check({tag, ".a.occupancy"}, 64'(a_if.occupancy), 64'(occ));
    check({tag, ".a.in_ready"}, 64'(a_if.in_ready), 64'(rdy));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [63:0] pc,
                       input logic [31:0] inst, input logic [1:0] occ, input logic rdy);
    check({tag, ".b.out_valid"}, 64'(b_if.out_valid), 64'(v));
    if (v) check({tag, ".b.out_pc"}, b_if.out_pc, pc);
    check({tag, ".b.out_inst"}, 64'(b_if.out_inst), 64'(inst));
    check({tag, ".b.occupancy"}, 64'(b_if.occupancy), 64'(occ));
    check({tag, ".b.in_ready"}, 64'(b_if.in_ready), 64'(rdy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
    a_if.in_valid  = v;
    a_if.in_pc     = pc;
    a_if.in_inst   = inst;
    a_if.out_ready = ordy;
    a_if.flush     = fl;
  endtask

  task automatic drive_b(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
    b_if.in_valid  = v;
    b_if.in_pc     = pc;
    b_if.in_inst   = inst;
    b_if.out_ready = ordy;
    b_if.flush     = fl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_a(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    drive_b(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    chk_a("reset", 1'b0, 64'h0, NOP, 2'd0, 1'b1);
    check("reset.a.out_pc", a_if.out_pc, 64'h0);
    chk_b("reset", 1'b0, 64'h0, NOP, 2'd0, 1'b1);
    reset = 1'b0;

    // Streaming at full rate
    drive_a(1'b1, 64'h1000, I0, 1'b1, 1'b0);
    step(); chk_a("stream0", 1'b1, 64'h1000, I0, 2'd1, 1'b1);
    drive_a(1'b1, 64'h1004, I1, 1'b1, 1'b0);
    step(); chk_a("stream1", 1'b1, 64'h1004, I1, 2'd1, 1'b1);
    drive_a(1'b1, 64'h1008, I2, 1'b1, 1'b0);
    step(); chk_a("stream2", 1'b1, 64'h1008, I2, 2'd1, 1'b1);
    drive_a(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    step(); chk_a("flush_one", 1'b0, 64'h0, NOP, 2'd0, 1'b1);

    // Backpressure fills the skid entry
    drive_a(1'b1, 64'h1000, I0, 1'b0, 1'b0);
    step(); chk_a("bp_load", 1'b1, 64'h1000, I0, 2'd1, 1'b1);
    drive_a(1'b1, 64'h1004, I1, 1'b0, 1'b0);
    step(); chk_a("bp_skid", 1'b1, 64'h1000, I0, 2'd2, 1'b0);
    drive_a(1'b1, 64'h1008, I2, 1'b0, 1'b0);
    step(); chk_a("bp_hold", 1'b1, 64'h1000, I0, 2'd2, 1'b0);
    step(); chk_a("bp_hold2", 1'b1, 64'h1000, I0, 2'd2, 1'b0);
    drive_a(1'b1, 64'h1008, I2, 1'b1, 1'b0);
    step(); chk_a("bp_drain1", 1'b1, 64'h1004, I1, 2'd1, 1'b1);
    step(); chk_a("bp_drain2", 1'b1, 64'h1008, I2, 2'd1, 1'b1);
    drive_a(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    step(); chk_a("bp_empty", 1'b0, 64'h0, NOP, 2'd0, 1'b1);

    // Flush while full with a beat offered
    drive_a(1'b1, 64'h3000, I0, 1'b0, 1'b0);
    step(); chk_a("ff_one", 1'b1, 64'h3000, I0, 2'd1, 1'b1);
    drive_a(1'b1, 64'h3004, I1, 1'b0, 1'b0);
    step(); chk_a("ff_full", 1'b1, 64'h3000, I0, 2'd2, 1'b0);
    drive_a(1'b1, 64'h2000, I2, 1'b0, 1'b1);
    step(); chk_a("ff_flush", 1'b0, 64'h0, NOP, 2'd0, 1'b1);
    check("ff_flush.a.out_pc_hold", a_if.out_pc, 64'h3000);
    drive_a(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    step(); chk_a("ff_after", 1'b0, 64'h0, NOP, 2'd0, 1'b1);

    // Flush and consume together, with an acceptable beat offered
    drive_a(1'b1, 64'h4000, I0, 1'b1, 1'b0);
    step(); chk_a("fc_one", 1'b1, 64'h4000, I0, 2'd1, 1'b1);
    drive_a(1'b1, 64'h4004, I1, 1'b1, 1'b1);
    step(); chk_a("fc_flush", 1'b0, 64'h0, NOP, 2'd0, 1'b1);
    drive_a(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    step(); chk_a("fc_after", 1'b0, 64'h0, NOP, 2'd0, 1'b1);

    // Asynchronous reset between edges while full
    drive_a(1'b1, 64'h5000, I0, 1'b0, 1'b0);
    step(); chk_a("ar_one", 1'b1, 64'h5000, I0, 2'd1, 1'b1);
    drive_a(1'b1, 64'h5004, I1, 1'b0, 1'b0);
    step(); chk_a("ar_full", 1'b1, 64'h5000, I0, 2'd2, 1'b0);
    drive_a(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_a("ar_async", 1'b0, 64'h0, NOP, 2'd0, 1'b1);
    check("ar_async.a.out_pc", a_if.out_pc, 64'h0);
    #1 reset = 1'b0;
    step(); chk_a("ar_after", 1'b0, 64'h0, NOP, 2'd0, 1'b1);

    // Build without skid: combinational ready, single entry
    drive_b(1'b1, 64'h6000, I0, 1'b0, 1'b0);
    step(); chk_b("nb_load", 1'b1, 64'h6000, I0, 2'd1, 1'b0);
    b_if.out_ready = 1'b1;
    #1;
    check("nb_comb_ready.b.in_ready", 64'(b_if.in_ready), 64'd1);
    drive_b(1'b1, 64'h6004, I1, 1'b1, 1'b0);
    step(); chk_b("nb_b2b1", 1'b1, 64'h6004, I1, 2'd1, 1'b1);
    drive_b(1'b1, 64'h6008, I2, 1'b1, 1'b0);
    step(); chk_b("nb_b2b2", 1'b1, 64'h6008, I2, 2'd1, 1'b1);
    drive_b(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    step(); chk_b("nb_empty", 1'b0, 64'h0, NOP, 2'd0, 1'b1);
    drive_b(1'b1, 64'h7000, I0, 1'b0, 1'b0);
    step(); chk_b("nb_one", 1'b1, 64'h7000, I0, 2'd1, 1'b0);
    drive_b(1'b1, 64'h7004, I1, 1'b0, 1'b1);
    step(); chk_b("nb_flush", 1'b0, 64'h0, NOP, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
